// File: rtl/opn_pkg.sv
// Shared types for the output-selector polarity detector: mode and status codes,
// FSM states and the window classification helper.
package opn_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_NORM = 2'b01,
    MODE_INV  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'b00,
    STAT_VALID   = 2'b01,
    STAT_UNKNOWN = 2'b10,
    STAT_AMBIG   = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    ACQ    = 2'b10,
    REPORT = 2'b11
  } state_t;

  typedef struct packed {
    mode_t   mode;
    status_t status;
  } result_t;

  localparam int          CNT_W   = 8;
  localparam logic [7:0]  CNT_MAX = 8'hFF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             hit);
    return (hit && value != CNT_MAX) ? value + 8'd1 : value;
  endfunction

  // A constant reference stream cannot tell the codes apart, so it is checked first.
  function automatic result_t classify(input logic [CNT_W-1:0] nm,
                                       input logic [CNT_W-1:0] ni,
                                       input logic [CNT_W-1:0] nz,
                                       input logic [CNT_W-1:0] n1,
                                       input logic [CNT_W-1:0] win,
                                       input logic [CNT_W-1:0] thr,
                                       input mode_t            held);
    result_t r;
    r.mode   = held;
    r.status = STAT_VALID;
    if (n1 == 8'd0 || n1 == win) begin
      r.status = STAT_AMBIG;
    end else if (nm <= thr) begin
      r.mode = MODE_NORM;
    end else if (ni <= thr) begin
      r.mode = MODE_INV;
    end else if (nz <= thr) begin
      r.mode = MODE_ZERO;
    end else begin
      r.status = STAT_UNKNOWN;
    end
    return r;
  endfunction

endpackage

// File: rtl/opn_delay_line.sv
// Shift register aligning the reference stream with the selector's returned line.
module opn_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data,
  output logic delayed
);

  logic [DEPTH-1:0] stages;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stages <= '0;
        else        stages <= data;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stages <= '0;
        else        stages <= {stages[DEPTH-2:0], data};
      end
    end
  endgenerate

  assign delayed = stages[DEPTH-1];

endmodule

// File: rtl/opn_detect.sv
// Classifies an external output selector as zero/normal/inverted by comparing its
// returned line with the delayed reference stream over a window.
// Optional feature: OPN_DET_TOLERANCE_EN allows ERR_TOL mismatches per window.
module opn_detect
  import opn_pkg::*;
#(
  parameter int WIN_LEN   = 64,
  parameter int EXT_DELAY = 0,
  parameter int ERR_TOL   = 2
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Sin,
  input  logic       Sext,
  input  logic       Start,
  input  logic       Cont,
  input  logic       Abort,
  output logic [1:0] Mode,
  output logic [1:0] Status,
  output logic       Done,
  output logic       Changed
);

  localparam int LAT = 1 + EXT_DELAY;

`ifdef OPN_DET_TOLERANCE_EN
  localparam int THR = ERR_TOL;
`else
  // Tolerance compiled out; ERR_TOL stays in the parameter list for drop-in compatibility.
  localparam int THR = ERR_TOL * 0;
`endif

  localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] THR_C    = CNT_W'(THR);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] nm, ni, nz, n1;
  logic [CNT_W-1:0] nm_nxt, ni_nxt, nz_nxt, n1_nxt;
  logic             sin_d;
  logic             in_acq, start_edge, report_edge, acq_entry;
  result_t          res;
  mode_t            mode_q;
  status_t          status_q;
  logic             done_q, changed_q, have_valid;

  opn_delay_line #(
    .DEPTH(LAT)
  ) u_delay (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .data   (Sin),
    .delayed(sin_d)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start)           state_nxt = FILL;
      FILL:    if (cyc == LAT_LAST) state_nxt = ACQ;
      ACQ:     if (cyc == WIN_LAST) state_nxt = REPORT;
      REPORT:  state_nxt = Cont ? ACQ : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Abort) state_nxt = IDLE;
  end

  always_comb begin
    in_acq      = (state == ACQ);
    start_edge  = (state == IDLE) && (state_nxt == FILL);
    report_edge = in_acq && (state_nxt == REPORT);
    acq_entry   = !in_acq && (state_nxt == ACQ);
    nm_nxt      = sat_inc(nm, in_acq && (Sext != sin_d));
    ni_nxt      = sat_inc(ni, in_acq && (Sext == sin_d));
    nz_nxt      = sat_inc(nz, in_acq && Sext);
    n1_nxt      = sat_inc(n1, in_acq && sin_d);
    res         = classify(nm_nxt, ni_nxt, nz_nxt, n1_nxt, WIN_C, THR_C, mode_q);
  end

  // One cycle counter serves both FILL and ACQ; it restarts on every state change.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cyc <= '0;
    end else if (state_nxt != state || !(state == FILL || state == ACQ)) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + 8'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      nm <= '0;
      ni <= '0;
      nz <= '0;
      n1 <= '0;
    end else if (acq_entry) begin
      nm <= '0;
      ni <= '0;
      nz <= '0;
      n1 <= '0;
    end else if (in_acq) begin
      nm <= nm_nxt;
      ni <= ni_nxt;
      nz <= nz_nxt;
      n1 <= n1_nxt;
    end
  end

  // The final window sample is folded in through the *_nxt counts at the REPORT edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q     <= MODE_ZERO;
      status_q   <= STAT_NONE;
      done_q     <= 1'b0;
      changed_q  <= 1'b0;
      have_valid <= 1'b0;
    end else begin
      done_q <= report_edge;
      if (start_edge) begin
        changed_q  <= 1'b0;
        have_valid <= 1'b0;
      end else if (report_edge) begin
        mode_q   <= res.mode;
        status_q <= res.status;
        if (res.status == STAT_VALID) begin
          have_valid <= 1'b1;
          if (have_valid && res.mode != mode_q) changed_q <= 1'b1;
        end
      end
    end
  end

  assign Mode    = mode_q;
  assign Status  = status_q;
  assign Done    = done_q;
  assign Changed = changed_q;

endmodule

// File: tb/tb_opn_detect.sv
// Directed bench for opn_detect: a modelled selector loop feeds two instances
// (EXT_DELAY 0 and 3); expected values are hand-computed per scenario.
module tb_opn_detect;

  localparam int WIN = 64;

`ifdef OPN_DET_TOLERANCE_EN
  localparam logic [1:0] EXP_E_MODE = 2'b01;
  localparam logic [1:0] EXP_E_STAT = 2'b01;
`else
  localparam logic [1:0] EXP_E_MODE = 2'b10;
  localparam logic [1:0] EXP_E_STAT = 2'b10;
`endif

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Sin = 1'b0;
  logic       start0 = 1'b0, start3 = 1'b0;
  logic       Cont = 1'b0, Abort = 1'b0;
  logic       hold_one = 1'b0, flip = 1'b0;
  logic [1:0] code = 2'b01;
  logic       sel_q = 1'b0, sel_fn;
  logic [2:0] pipe3 = 3'b000;
  logic [1:0] mode0, status0, mode3, status3;
  logic       done0, changed0, done3, changed3;

  int errors = 0;
  int checks = 0;
  int lat, cnt;

  always #5 Clock = ~Clock;

  always @(negedge Clock) Sin = hold_one ? 1'b1 : ~Sin;

  // Selector model: one register stage, then three extra stages for the second instance.
  always_comb begin
    sel_fn = 1'b0;
    if (code == 2'b01) sel_fn = Sin;
    else if (code == 2'b10) sel_fn = ~Sin;
  end

  always @(posedge Clock) begin
    sel_q <= sel_fn ^ flip;
    pipe3 <= {pipe3[1:0], sel_q};
  end

  opn_detect #(.WIN_LEN(WIN), .EXT_DELAY(0), .ERR_TOL(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Sin(Sin), .Sext(sel_q), .Start(start0),
    .Cont(Cont), .Abort(Abort), .Mode(mode0), .Status(status0), .Done(done0),
    .Changed(changed0)
  );

  opn_detect #(.WIN_LEN(WIN), .EXT_DELAY(3), .ERR_TOL(2)) dut3 (
    .Clock(Clock), .Reset_n(Reset_n), .Sin(Sin), .Sext(pipe3[2]), .Start(start3),
    .Cont(Cont), .Abort(Abort), .Mode(mode3), .Status(status3), .Done(done3),
    .Changed(changed3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulseStart(input bit use3);
    @(negedge Clock);
    if (use3) start3 = 1'b1; else start0 = 1'b1;
    @(posedge Clock);
    #1;
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  // lat = index of the edge that first captures Done high (Done rises one edge earlier).
  task automatic waitDone(input bit use3, input int max_cyc, output int lat_o);
    bit found = 0;
    lat_o = 0;
    for (int i = 1; i <= max_cyc && !found; i++) begin
      @(posedge Clock);
      #1;
      if ((use3 ? done3 : done0) === 1'b1) begin
        lat_o = i + 1;
        found = 1;
      end
    end
  endtask

  task automatic watchNoDone(input int n, output int cnt_o);
    cnt_o = 0;
    repeat (n) begin
      @(posedge Clock);
      #1;
      if (done0 !== 1'b0) cnt_o++;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input bit hold);
    @(negedge Clock);
    code     = sel;
    hold_one = hold;
    repeat (6) @(negedge Clock);
  endtask

  initial begin
    #1;
    checkOutput("rst_mode", mode0, 2'b00);
    checkOutput("rst_status", status0, 2'b00);
    checkOutput("rst_done", done0, 1'b0);
    checkOutput("rst_changed", changed0, 1'b0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    // Normal selector, EXT_DELAY 0
    applyStimulus(2'b01, 1'b0);
    pulseStart(1'b0);
    waitDone(1'b0, 200, lat);
    checkOutput("norm_lat", lat, 66);
    checkOutput("norm_mode", mode0, 2'b01);
    checkOutput("norm_status", status0, 2'b01);
    checkOutput("norm_changed", changed0, 1'b0);
    @(posedge Clock); #1;
    checkOutput("norm_done_pulse", done0, 1'b0);

    // Inverted selector, EXT_DELAY 3
    applyStimulus(2'b10, 1'b0);
    pulseStart(1'b1);
    waitDone(1'b1, 200, lat);
    checkOutput("inv_lat", lat, 69);
    checkOutput("inv_mode", mode3, 2'b10);
    checkOutput("inv_status", status3, 2'b01);

    // Constant-one reference; inverted selector would otherwise read as mode 10
    applyStimulus(2'b10, 1'b1);
    pulseStart(1'b0);
    waitDone(1'b0, 200, lat);
    checkOutput("amb_lat", lat, 66);
    checkOutput("amb_mode", mode0, 2'b01);
    checkOutput("amb_status", status0, 2'b11);

    // Continuous windows with the selector switched in the gap cycle
    applyStimulus(2'b01, 1'b0);
    Cont = 1'b1;
    pulseStart(1'b0);
    waitDone(1'b0, 200, lat);
    checkOutput("cont1_mode", mode0, 2'b01);
    checkOutput("cont1_changed", changed0, 1'b0);
    code = 2'b10;
    @(posedge Clock); #1;
    Cont = 1'b0;
    waitDone(1'b0, 200, lat);
    checkOutput("cont2_lat", lat, WIN + 1);
    checkOutput("cont2_mode", mode0, 2'b10);
    checkOutput("cont2_status", status0, 2'b01);
    checkOutput("cont2_changed", changed0, 1'b1);

    // Two forced mismatches in a normal stream
    applyStimulus(2'b01, 1'b0);
    pulseStart(1'b0);
    checkOutput("start_clears_changed", changed0, 1'b0);
    fork
      waitDone(1'b0, 200, lat);
      begin
        repeat (10) @(negedge Clock);
        flip = 1'b1;
        @(negedge Clock) flip = 1'b0;
        repeat (10) @(negedge Clock);
        flip = 1'b1;
        @(negedge Clock) flip = 1'b0;
      end
    join
    checkOutput("err_lat", lat, 66);
    checkOutput("err_mode", mode0, EXP_E_MODE);
    checkOutput("err_status", status0, EXP_E_STAT);

    // Abort mid-window, then Abort together with Start
    pulseStart(1'b0);
    repeat (30) @(posedge Clock);
    @(negedge Clock) Abort = 1'b1;
    @(posedge Clock); #1;
    Abort = 1'b0;
    watchNoDone(80, cnt);
    checkOutput("abort_no_done", cnt, 0);
    checkOutput("abort_mode_hold", mode0, EXP_E_MODE);
    checkOutput("abort_status_hold", status0, EXP_E_STAT);
    @(negedge Clock);
    start0 = 1'b1;
    Abort  = 1'b1;
    @(posedge Clock); #1;
    start0 = 1'b0;
    Abort  = 1'b0;
    watchNoDone(80, cnt);
    checkOutput("abort_beats_start", cnt, 0);
    pulseStart(1'b0);
    waitDone(1'b0, 200, lat);
    checkOutput("post_abort_lat", lat, 66);
    checkOutput("post_abort_mode", mode0, 2'b01);
    checkOutput("post_abort_status", status0, 2'b01);

    // Reset mid-window
    applyStimulus(2'b10, 1'b0);
    pulseStart(1'b0);
    repeat (30) @(posedge Clock);
    @(negedge Clock) Reset_n = 1'b0;
    #1;
    checkOutput("midrst_mode", mode0, 2'b00);
    checkOutput("midrst_status", status0, 2'b00);
    checkOutput("midrst_done", done0, 1'b0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    watchNoDone(80, cnt);
    checkOutput("midrst_no_done", cnt, 0);
    pulseStart(1'b0);
    waitDone(1'b0, 200, lat);
    checkOutput("post_rst_lat", lat, 66);
    checkOutput("post_rst_mode", mode0, 2'b10);
    checkOutput("post_rst_status", status0, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
